encoder_serial: RTL and testbench
=================================

# encoder_serial

Sequential 16-to-4 encoder: the inverse of the team's 4-to-16 one-hot decoder. It captures a 16-bit multi-hot vector and emits the 4-bit binary index of every set bit, one code per transfer, over a valid/ready handshake, then pulses `done`. It sits between a request/flag vector source and any consumer that needs binary indices, such as a decoder or an address generator.

## Interface
Parameters:
- None. Widths are fixed: 16-bit input vector, 4-bit code.

Ports:
- `clk` in 1 — single clock; all logic on the rising edge.
- `reset` in 1 — synchronous, active-high.
- `enable` in 1 — block enable. When low, the FSM, the pending register and all outputs hold, and no load or transfer occurs.
- `load` in 1 — capture `decoder_in`; honoured only in IDLE with `enable`=1.
- `decoder_in` in 16 — multi-hot vector to encode.
- `binary_out` out 4 — current code (index of a set bit).
- `out_valid` out 1 — `binary_out` is valid.
- `out_ready` in 1 — consumer accepts the code.
- `busy` out 1 — high in EMIT.
- `count_out` out 5 — popcount of the last loaded vector (0..16).
- `done` out 1 — one-cycle pulse after the last code transfers.
- `none` out 1 — one-cycle pulse when a zero vector is loaded.

## Operation
- Transfer occurs when `out_valid` & `out_ready` & `enable` are all high.
- Internal state: FSM {IDLE, EMIT}; `pend[15:0]` holds the set bits not yet emitted.
- Reset values: state=IDLE, `pend`=0, `binary_out`=0, `out_valid`=0, `busy`=0, `count_out`=0, `done`=0, `none`=0.
- **IDLE, load accepted:**
  - `pend` <= `decoder_in`; `count_out` <= popcount(`decoder_in`).
  - Nonzero vector: go to EMIT; `out_valid` <= 1; `binary_out` <= index of the lowest set bit; `busy` <= 1.
  - Zero vector: stay in IDLE; `none` pulses; `out_valid` stays 0.
- **EMIT, on transfer:**
  - Clear the emitted bit in `pend`.
  - If bits remain: `binary_out` <= next lowest index; `out_valid` stays 1 (back-to-back codes, one per cycle).
  - Otherwise: `out_valid` <= 0; `busy` <= 0; `done` pulses; go to IDLE.
- **EMIT, no transfer:** `binary_out` and `out_valid` hold. A `load` in EMIT is ignored, and `decoder_in` changes have no effect.
- Codes are strictly increasing within one vector, and each set bit is emitted exactly once.
- `count_out` holds until the next accepted load.

## Timing
- Load is sampled at edge N; `out_valid`, `binary_out`, `busy` and `count_out` are valid after edge N.
- Throughput: one code per cycle with `out_ready`=1. A vector with k set bits completes in k cycles after load.
- `done` is asserted for exactly the one cycle following the final transfer edge; `out_valid` is 0 in that cycle.
- `none` is asserted for the one cycle following the load edge.
- `load` in the same cycle that `done` is high is accepted, because the FSM is in IDLE. A new vector can therefore start every k+1 cycles.
- `binary_out` must not change while `out_valid`=1 and no transfer has occurred.
- `enable` low freezes the block completely, including mid-EMIT. Pulses do not re-fire; a pulse already asserted holds until the first enabled cycle.
- `reset` mid-EMIT abandons the vector: all outputs return to their reset values on the next edge and `done` is not pulsed. `reset` has priority over `load` and `enable`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `ENC_MSB_FIRST_EN`.
- Defined: scan from MSB to LSB. The highest set index is emitted first and codes are strictly decreasing.
- Undefined (default): LSB-first, codes strictly increasing.
- Handshake, counts, pulses and latency are identical in both builds.

## Test plan
- Load `16'h0001` with `out_ready`=1 -> one code `4'h0`, `count_out`=1, `done` pulses in the next cycle.
- Load `16'h8421` with `out_ready`=1 -> codes 0, 5, A, F on consecutive cycles, `count_out`=4, `done` pulses after F. With `ENC_MSB_FIRST_EN`: F, A, 5, 0.
- Load `16'h0003`, hold `out_ready`=0 for 3 cycles -> `binary_out`=0 and `out_valid`=1 stable throughout. Then `out_ready`=1 -> codes 0, 1, then `done`.
- Load `16'h0000` -> `none` pulses for 1 cycle, `out_valid` never rises, `count_out`=0.
- Load `16'hFFFF`; drop `enable` for 2 cycles after code 3; issue a second `load` during EMIT -> all outputs freeze during the 2 cycles, the second load is ignored, codes 0..F are emitted exactly once, `count_out`=16.
- Load `16'h00F0`; assert `reset` after 2 transfers -> all outputs are 0 on the next edge, with no `done` pulse. A fresh load of `16'h0100` afterwards -> code 8.

Source files
------------

// File: rtl/encoder_serial.sv
// encoder_serial
// ---------------------------------------------------------------------------
// Sequential 16-to-4 encoder. Captures a 16-bit multi-hot vector and emits
// the 4-bit index of every set bit, one code per valid/ready transfer, then
// pulses done. A zero vector pulses none instead of emitting anything.
//
// Ports:
//   clk         in   1  rising-edge clock
//   reset       in   1  synchronous, active-high reset
//   enable      in   1  block enable; low freezes every register
//   load        in   1  capture decoder_in (only honoured in IDLE)
//   decoder_in  in  16  multi-hot vector to encode
//   binary_out  out  4  current code
//   out_valid   out  1  binary_out is valid
//   out_ready   in   1  consumer accepts the current code
//   busy        out  1  high while codes are being emitted
//   count_out   out  5  popcount of the last accepted vector
//   done        out  1  one-cycle pulse after the final transfer
//   none        out  1  one-cycle pulse after loading a zero vector
//
// Configuration macro: ENC_MSB_FIRST_EN
//   undefined (default): lowest index emitted first, codes increasing
//   defined            : highest index emitted first, codes decreasing
// ---------------------------------------------------------------------------
module encoder_serial (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] decoder_in,
  output logic [3:0]  binary_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [4:0]  count_out,
  output logic        done,
  output logic        none
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      stateQ, stateD;
  logic [15:0] pendQ, pendD;
  logic [3:0]  binOutQ, binOutD;
  logic        outValidQ, outValidD;
  logic        busyQ, busyD;
  logic [4:0]  countQ, countD;
  logic        doneQ, doneD;
  logic        noneQ, noneD;

  logic        xfer;
  logic [15:0] remaining;

  // Index of the set bit that goes out first under the selected scan order.
  function automatic logic [3:0] scanFirst(input logic [15:0] vec);
    logic [3:0] idx;
    idx = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < 16; i++) begin
      if (vec[i]) idx = 4'(i);
    end
`else
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
`endif
    return idx;
  endfunction

  function automatic logic [4:0] popCount(input logic [15:0] vec);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(vec[i]);
    end
    return cnt;
  endfunction

  // The code on binary_out is always a set bit of pend, so clearing it
  // yields the bits still owed to the consumer.
  assign xfer      = outValidQ & out_ready & enable;
  assign remaining = pendQ & ~(16'h0001 << binOutQ);

  // State and datapath registers; reset wins over everything, and a low
  // enable leaves every register untouched because the *_d values hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= IDLE;
      pendQ     <= '0;
      binOutQ   <= '0;
      outValidQ <= 1'b0;
      busyQ     <= 1'b0;
      countQ    <= '0;
      doneQ     <= 1'b0;
      noneQ     <= 1'b0;
    end else begin
      stateQ    <= stateD;
      pendQ     <= pendD;
      binOutQ   <= binOutD;
      outValidQ <= outValidD;
      busyQ     <= busyD;
      countQ    <= countD;
      doneQ     <= doneD;
      noneQ     <= noneD;
    end
  end

  // Next-state logic: a nonzero load starts emission, the last transfer
  // returns to IDLE.
  always_comb begin
    stateD = stateQ;
    if (enable) begin
      case (stateQ)
        IDLE: if (load && (decoder_in != 16'h0000)) stateD = EMIT;
        EMIT: if (xfer && (remaining == 16'h0000)) stateD = IDLE;
        default: stateD = IDLE;
      endcase
    end
  end

  // Output/datapath next values. Pulses only clear on an enabled cycle so
  // that a frozen block keeps showing a pulse that was already up.
  always_comb begin
    pendD     = pendQ;
    binOutD   = binOutQ;
    outValidD = outValidQ;
    busyD     = busyQ;
    countD    = countQ;
    doneD     = doneQ;
    noneD     = noneQ;
    if (enable) begin
      doneD = 1'b0;
      noneD = 1'b0;
      case (stateQ)
        IDLE: begin
          if (load) begin
            pendD  = decoder_in;
            countD = popCount(decoder_in);
            if (decoder_in != 16'h0000) begin
              outValidD = 1'b1;
              busyD     = 1'b1;
              binOutD   = scanFirst(decoder_in);
            end else begin
              noneD = 1'b1;
            end
          end
        end
        EMIT: begin
          if (xfer) begin
            pendD = remaining;
            if (remaining != 16'h0000) begin
              binOutD = scanFirst(remaining);
            end else begin
              outValidD = 1'b0;
              busyD     = 1'b0;
              doneD     = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign binary_out = binOutQ;
  assign out_valid  = outValidQ;
  assign busy       = busyQ;
  assign count_out  = countQ;
  assign done       = doneQ;
  assign none       = noneQ;

endmodule

// File: tb/tb_encoder_serial.sv
// Testbench for encoder_serial: directed vectors, a queue-based reference
// model checked every cycle, and literal expectations on the emitted code
// sequences and on selected cycles.
module tb_encoder_serial;

  logic        clk = 1'b0;
  logic        reset, enable, load, out_ready;
  logic [15:0] decoder_in;
  logic [3:0]  binary_out;
  logic        out_valid, busy, done, none;
  logic [4:0]  count_out;

  int nComp = 0;
  int nFail = 0;

  // Reference model: the codes still owed, in emission order.
  logic [3:0] mQ[$];
  logic       mValid = 1'b0, mBusy = 1'b0, mDone = 1'b0, mNone = 1'b0;
  logic [4:0] mCount = '0;
  bit         checkOn = 1'b0;

  // Every code the DUT actually handed over, in order.
  logic [3:0] xferLog[$];

  encoder_serial dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .decoder_in (decoder_in),
    .binary_out (binary_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .count_out  (count_out),
    .done       (done),
    .none       (none)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nComp++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Record transfers and advance the model on each rising edge.
  always @(posedge clk) begin
    if (!reset && enable && out_valid && out_ready) xferLog.push_back(binary_out);
    if (reset) begin
      mQ.delete();
      mValid  = 1'b0;
      mBusy   = 1'b0;
      mDone   = 1'b0;
      mNone   = 1'b0;
      mCount  = '0;
      checkOn = 1'b1;
    end else if (enable) begin
      mDone = 1'b0;
      mNone = 1'b0;
      if (mValid) begin
        if (out_ready) begin
          void'(mQ.pop_front());
          if (mQ.size() == 0) begin
            mValid = 1'b0;
            mBusy  = 1'b0;
            mDone  = 1'b1;
          end
        end
      end else if (load) begin
`ifdef ENC_MSB_FIRST_EN
        for (int i = 15; i >= 0; i--) if (decoder_in[i]) mQ.push_back(4'(i));
`else
        for (int i = 0; i < 16; i++) if (decoder_in[i]) mQ.push_back(4'(i));
`endif
        mCount = 5'(mQ.size());
        if (mQ.size() == 0) mNone = 1'b1;
        else begin
          mValid = 1'b1;
          mBusy  = 1'b1;
        end
      end
    end
  end

  // Compare DUT against the model mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("out_valid", out_valid, mValid);
      checkOutput("busy", busy, mBusy);
      checkOutput("done", done, mDone);
      checkOutput("none", none, mNone);
      checkOutput("count_out", count_out, mCount);
      if (mValid && mQ.size() > 0) checkOutput("binary_out", binary_out, mQ[0]);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] vec, input logic rdy);
    load       = ld;
    decoder_in = vec;
    out_ready  = rdy;
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      cycles(1);
      n++;
    end
    checkOutput({name, "_done_seen"}, done, 1);
  endtask

  // Expected codes packed one per nibble, first emitted code in nibble 0.
  task automatic checkLog(input string name, input int start, input int n, input logic [63:0] exp);
    checkOutput({name, "_len"}, xferLog.size() - start, n);
    for (int i = 0; i < n; i++) begin
      if (start + i < xferLog.size())
        checkOutput($sformatf("%s[%0d]", name, i), xferLog[start + i], exp[4*i +: 4]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int start;
    reset = 1'b1; enable = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b1);
    cycles(3);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_code", binary_out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", count_out, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_none", none, 0);
    reset = 1'b0;
    cycles(1);

    // Single bit, then a new vector loaded in the done cycle.
    $display("[TB] vector 0001");
    start = xferLog.size();
    applyStimulus(1'b1, 16'h0001, 1'b1);
    cycles(1);
    checkOutput("t1_code", binary_out, 0);
    checkOutput("t1_count", count_out, 1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    cycles(1);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_valid", out_valid, 0);
    checkLog("t1_seq", start, 1, 64'h0);

    $display("[TB] vector 8421 loaded in done cycle");
    start = xferLog.size();
    applyStimulus(1'b1, 16'h8421, 1'b1);
    cycles(1);
    checkOutput("t2_done_clr", done, 0);
    checkOutput("t2_count", count_out, 4);
`ifdef ENC_MSB_FIRST_EN
    checkOutput("t2_first", binary_out, 4'hF);
`else
    checkOutput("t2_first", binary_out, 4'h0);
`endif
    applyStimulus(1'b0, 16'h0000, 1'b1);
    waitDone("t2", 20);
`ifdef ENC_MSB_FIRST_EN
    checkLog("t2_seq", start, 4, 64'h05AF);
`else
    checkLog("t2_seq", start, 4, 64'hFA50);
`endif
    cycles(1);

    // Back-pressure holds the first code.
    $display("[TB] vector 0003 with stall");
    start = xferLog.size();
    applyStimulus(1'b1, 16'h0003, 1'b0);
    cycles(1);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    cycles(3);
    checkOutput("t3_valid_held", out_valid, 1);
`ifdef ENC_MSB_FIRST_EN
    checkOutput("t3_code_held", binary_out, 1);
`else
    checkOutput("t3_code_held", binary_out, 0);
`endif
    applyStimulus(1'b0, 16'h0000, 1'b1);
    waitDone("t3", 10);
`ifdef ENC_MSB_FIRST_EN
    checkLog("t3_seq", start, 2, 64'h01);
`else
    checkLog("t3_seq", start, 2, 64'h10);
`endif
    cycles(1);

    // Zero vector; none is frozen by enable low and clears afterwards.
    $display("[TB] vector 0000");
    start = xferLog.size();
    applyStimulus(1'b1, 16'h0000, 1'b1);
    cycles(1);
    checkOutput("t4_none", none, 1);
    checkOutput("t4_count", count_out, 0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    enable = 1'b0;
    cycles(2);
    checkOutput("t4_none_frozen", none, 1);
    enable = 1'b1;
    cycles(1);
    checkOutput("t4_none_clr", none, 0);
    checkOutput("t4_valid", out_valid, 0);
    checkLog("t4_seq", start, 0, 64'h0);

    // Full vector with a freeze and an ignored load mid-emission.
    $display("[TB] vector FFFF with freeze");
    start = xferLog.size();
    applyStimulus(1'b1, 16'hFFFF, 1'b1);
    cycles(1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    cycles(3);
    enable = 1'b0;
    applyStimulus(1'b1, 16'h00FF, 1'b1);
    cycles(2);
`ifdef ENC_MSB_FIRST_EN
    checkOutput("t5_frozen_code", binary_out, 4'hC);
`else
    checkOutput("t5_frozen_code", binary_out, 4'h3);
`endif
    checkOutput("t5_frozen_valid", out_valid, 1);
    enable = 1'b1;
    cycles(1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    waitDone("t5", 30);
    checkOutput("t5_count", count_out, 16);
`ifdef ENC_MSB_FIRST_EN
    checkLog("t5_seq", start, 16, 64'h0123456789ABCDEF);
`else
    checkLog("t5_seq", start, 16, 64'hFEDCBA9876543210);
`endif
    cycles(1);

    // Reset mid-emission, then a fresh vector.
    $display("[TB] vector 00F0 with reset");
    start = xferLog.size();
    applyStimulus(1'b1, 16'h00F0, 1'b1);
    cycles(1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    cycles(2);
    reset = 1'b1;
    cycles(1);
    checkOutput("t6_rst_valid", out_valid, 0);
    checkOutput("t6_rst_code", binary_out, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_count", count_out, 0);
    checkOutput("t6_rst_done", done, 0);
`ifdef ENC_MSB_FIRST_EN
    checkLog("t6_seq", start, 2, 64'h67);
`else
    checkLog("t6_seq", start, 2, 64'h54);
`endif
    reset = 1'b0;
    cycles(1);
    checkOutput("t6_no_done", done, 0);
    start = xferLog.size();
    applyStimulus(1'b1, 16'h0100, 1'b1);
    cycles(1);
    checkOutput("t6_code8", binary_out, 8);
    checkOutput("t6_count", count_out, 1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    waitDone("t6", 10);
    checkLog("t6_fresh", start, 1, 64'h8);
    cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
    $finish;
  end

endmodule
